// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: drives one external full adder cell LSB first,
// recirculating the carry internally, behind a start/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_fa_a,
  output logic             o_fa_b,
  output logic             o_fa_cin,
  input  logic             i_fa_s,
  input  logic             i_fa_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // The newest sum bit enters at the top; on the final edge this is the full result.
  assign sum_nxt  = {i_fa_s, sum_sr};
  assign last_bit = (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_fa_a    = 1'b0;
    o_fa_b    = 1'b0;
    o_fa_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = RUN;
      end
      RUN: begin
        o_busy   = 1'b1;
        o_fa_a   = a_sr[0];
        o_fa_b   = b_sr[0];
        o_fa_cin = carry;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_clr) state_nxt = IDLE;
  end

  // Abort leaves the datapath untouched so the last good result stays visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      o_sum  <= '0;
      o_cout <= 1'b0;
    end else if (!i_clr) begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sr  <= i_a;
            b_sr  <= i_b;
            carry <= i_cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt[WIDTH-1:1];
          carry  <= i_fa_cout;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            o_sum  <= sum_nxt;
            o_cout <= i_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table of adds plus abort, ignored-start
// and asynchronous-reset sequences, with a behavioural full adder cell.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic             i_clr;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_fa_a;
  logic             o_fa_b;
  logic             o_fa_cin;
  logic             i_fa_s;
  logic             i_fa_cout;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  int checks = 0;
  int errors = 0;

  int         busy_cnt;
  int         done_cnt;
  int         done_cyc;
  int         idle_fa;
  logic [7:0] fa_a_seq;
  logic [7:0] fa_b_seq;
  logic [7:0] fa_cin_seq;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_clr     (i_clr),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_cin     (i_cin),
    .o_fa_a    (o_fa_a),
    .o_fa_b    (o_fa_b),
    .o_fa_cin  (o_fa_cin),
    .i_fa_s    (i_fa_s),
    .i_fa_cout (i_fa_cout),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_sum     (o_sum),
    .o_cout    (o_cout)
  );

  // The parent-level full adder cell the sequencer drives.
  assign i_fa_s    = o_fa_a ^ o_fa_b ^ o_fa_cin;
  assign i_fa_cout = (o_fa_a & o_fa_b) | (o_fa_a & o_fa_cin) | (o_fa_b & o_fa_cin);

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge i_clk);
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  // Fixed observation window after a start edge; cycle c is the one after edge k+c-1.
  task automatic observe(input int inj_cyc, input bit inj_start, input bit inj_clr);
    busy_cnt   = 0;
    done_cnt   = 0;
    done_cyc   = 0;
    idle_fa    = 0;
    fa_a_seq   = '0;
    fa_b_seq   = '0;
    fa_cin_seq = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge i_clk);
      if (o_busy) begin
        if (busy_cnt < 8) begin
          fa_a_seq[busy_cnt]   = o_fa_a;
          fa_b_seq[busy_cnt]   = o_fa_b;
          fa_cin_seq[busy_cnt] = o_fa_cin;
        end
        busy_cnt++;
      end else if (o_fa_a | o_fa_b | o_fa_cin) begin
        idle_fa++;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == inj_cyc) begin
        if (inj_start) begin
          i_a     = 8'hAA;
          i_start = 1'b1;
        end
        if (inj_clr) i_clr = 1'b1;
      end
      if (c == inj_cyc + 1) begin
        i_start = 1'b0;
        i_clr   = 1'b0;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(o_done), 32'h0);
    checkOutput({tag, "_sum"}, 32'(o_sum), 32'h0);
    checkOutput({tag, "_cout"}, 32'(o_cout), 32'h0);
    checkOutput({tag, "_fa"}, 32'({o_fa_a, o_fa_b, o_fa_cin}), 32'h0);
  endtask

  initial begin
    logic [8:0] full;
    logic [7:0] cin_exp;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[7] = '{8'h7E, 8'h03, 1'b1, 8'h82, 1'b0};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_clr   = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_cin   = 1'b0;
    #23;
    checkAllZero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      full    = 9'(vecs[v].a) + 9'(vecs[v].b) + 9'(vecs[v].cin);
      cin_exp = full[7:0] ^ vecs[v].a ^ vecs[v].b;
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].cin);
      observe(0, 1'b0, 1'b0);
      $display("[TB] vector %0d: 0x%0h + 0x%0h + %0d", v, vecs[v].a, vecs[v].b, vecs[v].cin);
      checkOutput("sum", 32'(o_sum), 32'(vecs[v].sum));
      checkOutput("cout", 32'(o_cout), 32'(vecs[v].cout));
      checkOutput("model_sum", 32'(o_sum), 32'(full[7:0]));
      checkOutput("busy_cycles", 32'(busy_cnt), 32'd8);
      checkOutput("done_cycle", 32'(done_cyc), 32'd9);
      checkOutput("done_pulses", 32'(done_cnt), 32'd1);
      checkOutput("fa_a_seq", 32'(fa_a_seq), 32'(vecs[v].a));
      checkOutput("fa_b_seq", 32'(fa_b_seq), 32'(vecs[v].b));
      checkOutput("fa_cin_seq", 32'(fa_cin_seq), 32'(cin_exp));
      checkOutput("idle_fa", 32'(idle_fa), 32'd0);
    end

    // Second start in RUN cycle 3 must not disturb the first operation.
    applyStimulus(8'h12, 8'h34, 1'b0);
    observe(3, 1'b1, 1'b0);
    checkOutput("ign_sum", 32'(o_sum), 32'h46);
    checkOutput("ign_cout", 32'(o_cout), 32'h0);
    checkOutput("ign_done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("ign_busy_cycles", 32'(busy_cnt), 32'd8);

    // Abort in RUN cycle 4: no done, previous result held.
    applyStimulus(8'h80, 8'h80, 1'b0);
    observe(4, 1'b0, 1'b1);
    checkOutput("clr_busy_cycles", 32'(busy_cnt), 32'd4);
    checkOutput("clr_done_pulses", 32'(done_cnt), 32'd0);
    checkOutput("clr_sum_held", 32'(o_sum), 32'h46);
    checkOutput("clr_cout_held", 32'(o_cout), 32'h0);

    applyStimulus(8'h70, 8'h0F, 1'b0);
    observe(0, 1'b0, 1'b0);
    checkOutput("post_clr_sum", 32'(o_sum), 32'h7F);
    checkOutput("post_clr_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset between clock edges mid-RUN.
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(negedge i_clk);
    checkOutput("pre_rst_busy", 32'(o_busy), 32'h1);
    checkOutput("pre_rst_sum", 32'(o_sum), 32'h7F);
    #2 i_rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(8'h01, 8'h01, 1'b0);
    observe(0, 1'b0, 1'b0);
    checkOutput("post_rst_sum", 32'(o_sum), 32'h02);
    checkOutput("post_rst_cout", 32'(o_cout), 32'h0);
    checkOutput("post_rst_done", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
